// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StDiscard,
    StHold
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  localparam int unsigned Rs1Lsb = 15;
  localparam int unsigned Rs1Msb = 19;
  localparam int unsigned Rs2Lsb = 20;
  localparam int unsigned Rs2Msb = 24;

  function automatic logic [4:0] rs1_field(input logic [31:0] instr);
    return instr[Rs1Msb:Rs1Lsb];
  endfunction

  function automatic logic [4:0] rs2_field(input logic [31:0] instr);
    return instr[Rs2Msb:Rs2Lsb];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that arrived while IF/ID was stalled.
module fetch_skid_buffer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  // Synchronous reset; flush (drain or redirect) wins over a same-cycle load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, IF/ID output register and a skid entry.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hu_in_stall_if_en_l,
  input  logic        ex_in_redirect_en_l,
  input  logic [31:0] ex_in_redirect_pc_l,
  output logic        fu_out_imem_req_w,
  output logic [31:0] fu_out_imem_addr_w,
  input  logic        imem_in_valid_l,
  input  logic [31:0] imem_in_rdata_l,
  output logic [31:0] fu_out_instr_w,
  output logic [31:0] fu_out_pc_w,
  output logic        fu_out_valid_w,
  output logic [4:0]  fu_out_rs1_key_w,
  output logic [4:0]  fu_out_rs2_key_w
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  out_instr_q;
  logic [31:0]  out_pc_q;
  logic         out_valid_q;

  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;
  logic         skid_valid;
  logic         skid_load;
  logic         skid_flush;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Gated by reset so no request is visible while reset is held.
  assign fu_out_imem_req_w  = reset & (state_q != StHold);
  assign fu_out_imem_addr_w = (state_q == StDiscard) ? addr_q : pc_q;

  assign skid_load  = !ex_in_redirect_en_l && (state_q == StFetch) && imem_in_valid_l &&
                      out_valid_q && hu_in_stall_if_en_l;
  assign skid_flush = ex_in_redirect_en_l || ((state_q == StHold) && !hu_in_stall_if_en_l);

  fetch_skid_buffer u_skid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (skid_load),
    .flush_i (skid_flush),
    .instr_i (imem_in_rdata_l),
    .pc_i    (pc_q),
    .instr_o (skid_instr),
    .pc_o    (skid_pc),
    .valid_o (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      addr_q      <= 32'h0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
      out_valid_q <= 1'b0;
    end else if (ex_in_redirect_en_l) begin
      pc_q        <= ex_in_redirect_pc_l;
      out_valid_q <= 1'b0;
      // An unanswered request must still be drained; keep its address on the bus.
      if ((state_q != StHold) && !imem_in_valid_l) begin
        state_q <= StDiscard;
        if (state_q == StFetch) addr_q <= pc_q;
      end else begin
        state_q <= StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_in_valid_l) begin
            pc_q <= pc_plus4;
            if (!out_valid_q || !hu_in_stall_if_en_l) begin
              out_instr_q <= imem_in_rdata_l;
              out_pc_q    <= pc_q;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StHold;
            end
          end else if (!hu_in_stall_if_en_l) begin
            out_valid_q <= 1'b0;
          end
        end
        StHold: begin
          if (!hu_in_stall_if_en_l) begin
            out_instr_q <= skid_instr;
            out_pc_q    <= skid_pc;
            out_valid_q <= skid_valid;
            state_q     <= StFetch;
          end
        end
        StDiscard: begin
          if (imem_in_valid_l) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign fu_out_instr_w   = out_instr_q;
  assign fu_out_pc_w      = out_pc_q;
  assign fu_out_valid_w   = out_valid_q;
  assign fu_out_rs1_key_w = out_valid_q ? rs1_field(out_instr_q) : 5'd0;
  assign fu_out_rs2_key_w = out_valid_q ? rs2_field(out_instr_q) : 5'd0;

endmodule
